// File: rtl/pdm_stereo_decimator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pdm_stereo_decimator: stereo PDM clock/capture with boxcar decimation     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module pdm_stereo_decimator #(
  parameter int CLK_FREQ    = 125,
  parameter int SAMPLE_RATE = 2400000,
  parameter int DEC_RATIO   = 128,
  localparam int CLK_COUNT  = (CLK_FREQ * 1000000) / (SAMPLE_RATE * 2),
  localparam int PCM_W      = $clog2(DEC_RATIO + 1)
) (
  input  logic             CLK_IN,
  input  logic             RST_N,
  input  logic             ENABLE,
  output logic             M_CLK,
  input  logic             M_DATA,
  output logic [PCM_W-1:0] PCM_L,
  output logic [PCM_W-1:0] PCM_R,
  output logic             PCM_VALID,
  input  logic             PCM_READY,
  output logic [7:0]       OVERRUN_CNT
);

  localparam int HC_W = $clog2(CLK_COUNT);
  localparam int PC_W = $clog2(DEC_RATIO);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_COUNT - 1);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(DEC_RATIO - 1);

  if (CLK_COUNT < 4) begin : g_clk_count_check
    $error("pdm_stereo_decimator: CLK_COUNT must be at least 4");
  end

  if ((DEC_RATIO < 16) || (DEC_RATIO > 1024) || ((DEC_RATIO & (DEC_RATIO - 1)) != 0))
  begin : g_dec_ratio_check
    $error("pdm_stereo_decimator: DEC_RATIO must be a power of two in 16..1024");
  end

  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic [HC_W-1:0]  hc_q, hc_d;
  logic             mclk_q, mclk_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PCM_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [PCM_W-1:0] pcm_l_q, pcm_l_d, pcm_r_q, pcm_r_d;
  logic             valid_q, valid_d;
  logic [7:0]       ovf_q, ovf_d;

  logic             terminal, rise_evt, fall_evt, window_end, load;
  logic [PCM_W-1:0] win_r;

  always_comb begin
    terminal   = ENABLE && (hc_q == HC_LAST);
    rise_evt   = terminal && !mclk_q;
    fall_evt   = terminal && mclk_q;
    window_end = fall_evt && (pc_q == PC_LAST);
    // The right channel's last sample lands on the window-end cycle itself.
    win_r      = acc_r_q + PCM_W'(sync2_q);
    load       = window_end && (!valid_q || PCM_READY);

    sync1_d = M_DATA;
    sync2_d = sync1_q;
    hc_d    = hc_q;
    mclk_d  = mclk_q;
    pc_d    = pc_q;
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    pcm_l_d = pcm_l_q;
    pcm_r_d = pcm_r_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;

    if (!ENABLE) begin
      hc_d    = '0;
      mclk_d  = 1'b0;
      pc_d    = '0;
      acc_l_d = '0;
      acc_r_d = '0;
    end else if (terminal) begin
      hc_d   = '0;
      mclk_d = !mclk_q;
      if (rise_evt) begin
        acc_l_d = acc_l_q + PCM_W'(sync2_q);
      end
      if (fall_evt) begin
        pc_d    = pc_q + 1'b1;
        acc_r_d = win_r;
        if (window_end) begin
          acc_l_d = '0;
          acc_r_d = '0;
        end
      end
    end else begin
      hc_d = hc_q + 1'b1;
    end

    if (load) begin
      pcm_l_d = acc_l_q;
      pcm_r_d = win_r;
      valid_d = 1'b1;
    end else if (PCM_READY) begin
      valid_d = 1'b0;
    end

    if (window_end && valid_q && !PCM_READY && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hc_q    <= '0;
      mclk_q  <= 1'b0;
      pc_q    <= '0;
      acc_l_q <= '0;
      acc_r_q <= '0;
      pcm_l_q <= '0;
      pcm_r_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hc_q    <= hc_d;
      mclk_q  <= mclk_d;
      pc_q    <= pc_d;
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      pcm_l_q <= pcm_l_d;
      pcm_r_q <= pcm_r_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign M_CLK       = mclk_q;
  assign PCM_L       = pcm_l_q;
  assign PCM_R       = pcm_r_q;
  assign PCM_VALID   = valid_q;
  assign OVERRUN_CNT = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pdm_stereo_decimator.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pdm_stereo_decimator: directed/random bench with a window-level model  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_pdm_stereo_decimator;

  localparam int D          = 64;  // shorter window keeps the run brief
  localparam int CC         = 26;  // 125 MHz / (2 * 2.4 MHz)
  localparam int HALF_LIMIT = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       m_data = 1'b0;
  logic       pcm_ready = 1'b0;
  logic       m_clk;
  logic [6:0] pcm_l, pcm_r;
  logic       pcm_valid;
  logic [7:0] ovf;

  pdm_stereo_decimator #(
    .CLK_FREQ   (125),
    .SAMPLE_RATE(2400000),
    .DEC_RATIO  (D)
  ) dut (
    .CLK_IN     (clk),
    .RST_N      (rst_n),
    .ENABLE     (enable),
    .M_CLK      (m_clk),
    .M_DATA     (m_data),
    .PCM_L      (pcm_l),
    .PCM_R      (pcm_r),
    .PCM_VALID  (pcm_valid),
    .PCM_READY  (pcm_ready),
    .OVERRUN_CNT(ovf)
  );

  always #4 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit stuck = 1'b0;
  int hmin, hmax, wcycles;

  // Window-level model of the output stage
  bit mv = 1'b0;
  int ml = 0, mr = 0, movf = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_toggle(output int n);
    logic prev;
    prev = m_clk;
    n = 0;
    if (stuck) return;
    do begin
      tick();
      n++;
    end while ((m_clk === prev) && (n < HALF_LIMIT));
    if (m_clk === prev) begin
      stuck = 1'b1;
      check("mclk_toggle", m_clk, !prev);
    end
  endtask

  // Drive one bit per M_CLK phase: l during the low phase, r during the high phase.
  task automatic do_periods(input int n, input logic [D-1:0] l, input logic [D-1:0] r);
    int h;
    hmin = 1 << 30; hmax = 0; wcycles = 0;
    for (int p = 0; p < n; p++) begin
      for (int ph = 0; ph < 2; ph++) begin
        m_data = (ph == 0) ? l[p] : r[p];
        wait_toggle(h);
        wcycles += h;
        if (h < hmin) hmin = h;
        if (h > hmax) hmax = h;
      end
    end
  endtask

  task automatic do_window(input string tag, input logic [D-1:0] l, input logic [D-1:0] r);
    do_periods(D, l, r);
    if (mv && !pcm_ready) begin
      if (movf < 255) movf++;
    end else begin
      mv = 1'b1;
      ml = $countones(l);
      mr = $countones(r);
    end
    check({tag, "_valid"}, pcm_valid, mv);
    check({tag, "_l"}, pcm_l, ml);
    check({tag, "_r"}, pcm_r, mr);
    check({tag, "_ovf"}, ovf, movf);
    if (pcm_ready) begin
      tick();
      mv = 1'b0;
      check({tag, "_xfer"}, pcm_valid, 1'b0);
    end
  endtask

  function automatic logic [D-1:0] rand_k(input int k);
    logic [D-1:0] v;
    v = '0;
    while ($countones(v) < k) v[$urandom_range(D-1, 0)] = 1'b1;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [D-1:0] a, b;
    int quiet;

    // Reset state
    repeat (3) tick();
    check("rst_mclk", m_clk, 1'b0);
    check("rst_l", pcm_l, 0);
    check("rst_r", pcm_r, 0);
    check("rst_valid", pcm_valid, 1'b0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    tick();

    // All ones, clock shape and first-window latency
    pcm_ready = 1'b1;
    m_data = 1'b1;
    enable = 1'b1;
    do_window("ones", '1, '1);
    check("half_min", hmin, CC);
    check("half_max", hmax, CC);
    check("first_win_cycles", wcycles, D * 2 * CC);

    // Stereo phase separation
    do_window("left_only", '1, '0);
    do_window("right_only", '0, '1);

    // Fixed-density and fully random patterns, then silence
    do_window("quarter", rand_k(D / 4), rand_k(3 * D / 4));
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    do_window("random", a, b);
    do_window("zero", '0, '0);

    // Back-pressure across three window ends
    pcm_ready = 1'b0;
    do_window("stall1", {$urandom, $urandom}, {$urandom, $urandom});
    do_window("stall2", '1, '0);
    do_window("stall3", '0, '1);
    pcm_ready = 1'b1;
    tick();
    mv = 1'b0;
    check("stall_release_valid", pcm_valid, 1'b0);
    check("stall_release_ovf", ovf, 2);
    do_window("after_stall", rand_k(10), rand_k(50));

    // Drop ENABLE mid-window during the high phase
    do_periods(60, '1, '1);
    m_data = 1'b1;
    wait_toggle(quiet);
    repeat (3) tick();
    enable = 1'b0;
    tick();
    check("disable_mclk", m_clk, 1'b0);
    quiet = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (m_clk !== 1'b0 || pcm_valid !== 1'b0) quiet++;
    end
    check("disabled_quiet", quiet, 0);
    a = rand_k(20);
    b = rand_k(5);
    m_data = a[0];
    enable = 1'b1;
    do_window("reenable", a, b);
    check("reenable_cycles", wcycles, D * 2 * CC);

    // Asynchronous reset with a held beat mid-window
    pcm_ready = 1'b0;
    do_window("pre_reset", rand_k(40), rand_k(30));
    do_periods(20, '1, '1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_mclk", m_clk, 1'b0);
    check("async_rst_l", pcm_l, 0);
    check("async_rst_r", pcm_r, 0);
    check("async_rst_valid", pcm_valid, 1'b0);
    check("async_rst_ovf", ovf, 0);
    mv = 1'b0;
    movf = 0;
    repeat (2) tick();
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    m_data = a[0];
    pcm_ready = 1'b1;
    rst_n = 1'b1;
    do_window("post_reset", a, b);
    check("post_reset_cycles", wcycles, D * 2 * CC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
